// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive capture states, stop-bit options
// and the frame decode helpers used by the receive controller.
package uart_pkg;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE1 = 2'b11;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    typedef enum logic [1:0] {
        ARM    = 2'b00,
        WAIT   = 2'b01,
        COMMIT = 2'b10
    } cap_state_e;

    // With parity the data sits in the low byte; without it the frame is shifted by one.
    function automatic logic [7:0] frame_data(input logic [8:0] frame, input logic [1:0] mode);
        case (mode)
            PAR_ODD, PAR_EVEN: frame_data = frame[7:0];
            default:           frame_data = frame[8:1];
        endcase
    endfunction

    function automatic logic parity_err(input logic [8:0] frame, input logic [1:0] mode);
        case (mode)
            PAR_ODD:  parity_err = ~(^frame);
            PAR_EVEN: parity_err = ^frame;
            default:  parity_err = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side bus of the receive controller: pop/clear requests and FIFO/status readback.
interface uart_rx_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              rd_perr;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic [7:0]        perr_cnt;
    logic              clear;
    logic              irq;

    modport master (
        output rd_en, clear,
        input  rd_data, rd_perr, empty, full, level, overrun, perr_cnt, irq
    );

    modport slave (
        input  rd_en, clear,
        output rd_data, rd_perr, empty, full, level, overrun, perr_cnt, irq
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with registered level/full/empty; storage clears on reset.
module uart_sync_fifo #(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              do_pop_s, do_push_s;

    // A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
    assign do_pop_s  = pop & ~empty_q;
    assign do_push_s = push & (~full_q | do_pop_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == (ADDR_W+1)'(DEPTH));
        empty_d = (level_d == (ADDR_W+1)'(0));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign level   = level_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: captures one frame per rx_complete rise, checks parity and
// queues tagged bytes for the host, with sticky overrun, error count and irq.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int IRQ_LEVEL = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    cfg_parity,
    input  logic          rx_complete,
    input  logic [8:0]    rx_frame,
    uart_rx_ctrl_if.slave host
);
    cap_state_e      state_q, state_d;
    logic [8:0]      frame_q, frame_d;
    logic [1:0]      par_q, par_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      perr_cnt_q, perr_cnt_d;
    logic            irq_q, irq_d;
    logic            commit_s, perr_s, push_s, drop_s, perr_inc_s;
    logic [8:0]      fifo_rd_s;
    logic            fifo_empty_s, fifo_full_s;
    logic [ADDR_W:0] fifo_level_s;

    // Capture FSM: ARM insists on a low rx_complete so a held-high level is never recaptured.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        par_d    = par_q;
        commit_s = 1'b0;
        case (state_q)
            ARM: begin
                if (!rx_complete) begin
                    state_d = WAIT;
                end else begin
                    state_d = ARM;
                end
            end
            WAIT: begin
                if (rx_complete) begin
                    frame_d = rx_frame;
                    par_d   = cfg_parity;
                    state_d = COMMIT;
                end else begin
                    state_d = WAIT;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                state_d  = ARM;
            end
            default: state_d = ARM;
        endcase
    end

    // Commit decision and status updates; same-cycle events win over clear.
    always_comb begin
        perr_s     = parity_err(frame_q, par_q);
        push_s     = commit_s & (~fifo_full_s | host.rd_en);
        drop_s     = commit_s & fifo_full_s & ~host.rd_en;
        perr_inc_s = commit_s & perr_s;
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (host.clear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (perr_inc_s) begin
            if (host.clear) begin
                perr_cnt_d = 8'd1;
            end else if (perr_cnt_q == 8'hFF) begin
                perr_cnt_d = perr_cnt_q;
            end else begin
                perr_cnt_d = perr_cnt_q + 8'd1;
            end
        end else if (host.clear) begin
            perr_cnt_d = 8'd0;
        end else begin
            perr_cnt_d = perr_cnt_q;
        end
        irq_d = (fifo_level_s >= (ADDR_W+1)'(IRQ_LEVEL)) | overrun_q;
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ARM;
            frame_q    <= 9'd0;
            par_q      <= PAR_NONE0;
            overrun_q  <= 1'b0;
            perr_cnt_q <= 8'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            par_q      <= par_d;
            overrun_q  <= overrun_d;
            perr_cnt_q <= perr_cnt_d;
            irq_q      <= irq_d;
        end
    end

    uart_sync_fifo #(
        .ADDR_W (ADDR_W),
        .WIDTH  (9)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .wr_data ({perr_s, frame_data(frame_q, par_q)}),
        .pop     (host.rd_en),
        .rd_data (fifo_rd_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .level   (fifo_level_s)
    );

    assign host.rd_data  = fifo_rd_s[7:0];
    assign host.rd_perr  = fifo_rd_s[8];
    assign host.empty    = fifo_empty_s;
    assign host.full     = fifo_full_s;
    assign host.level    = fifo_level_s;
    assign host.overrun  = overrun_q;
    assign host.perr_cnt = perr_cnt_q;
    assign host.irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based model of the receive path.
module tb_uart_rx_ctrl;
    localparam int ADDR_W    = 3;
    localparam int IRQ_LEVEL = 4;
    localparam int DEPTH     = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] cfg_parity;
    logic       rx_complete;
    logic [8:0] rx_frame;

    uart_rx_ctrl_if #(.ADDR_W(ADDR_W)) host ();

    uart_rx_ctrl #(
        .ADDR_W    (ADDR_W),
        .IRQ_LEVEL (IRQ_LEVEL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_parity  (cfg_parity),
        .rx_complete (rx_complete),
        .rx_frame    (rx_frame),
        .host        (host)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: FIFO contents as {perr, data} entries plus status.
    logic [8:0] mq[$];
    bit         m_ov;
    int         m_perr;
    bit         m_irq;
    bit         m_pend;
    logic [8:0] m_pend_ent;
    bit         m_prev_rc;
    int         pop_mode;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model_entry(input logic [8:0] frame, input logic [1:0] cfg);
        int ones;
        ones = $countones(frame);
        if (cfg == 2'b01)      return {(ones % 2 == 0), frame[7:0]};
        else if (cfg == 2'b10) return {(ones % 2 == 1), frame[7:0]};
        else                   return {1'b0, frame[8:1]};
    endfunction

    task automatic set_rd();
        case (pop_mode)
            0:       host.rd_en = 1'b0;
            1:       host.rd_en = 1'b1;
            default: host.rd_en = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Advance the model by one clock using the inputs about to be sampled, then compare.
    task automatic tick();
        int sz;
        bit nxt_irq, ov_ev, perr_ev;
        sz = mq.size();
        ov_ev = 1'b0;
        perr_ev = 1'b0;
        if (!reset_n) begin
            mq.delete();
            m_ov = 1'b0; m_perr = 0; m_irq = 1'b0; m_pend = 1'b0;
        end else begin
            nxt_irq = (sz >= IRQ_LEVEL) || m_ov;
            if (host.rd_en && sz > 0) void'(mq.pop_front());
            if (m_pend) begin
                if (sz < DEPTH || host.rd_en) mq.push_back(m_pend_ent);
                else ov_ev = 1'b1;
                perr_ev = m_pend_ent[8];
            end
            if (ov_ev) m_ov = 1'b1;
            else if (host.clear) m_ov = 1'b0;
            if (perr_ev) m_perr = host.clear ? 1 : (m_perr < 255 ? m_perr + 1 : 255);
            else if (host.clear) m_perr = 0;
            m_irq = nxt_irq;
            m_pend = rx_complete && !m_prev_rc;
            if (m_pend) m_pend_ent = model_entry(rx_frame, cfg_parity);
        end
        m_prev_rc = rx_complete;
        @(posedge clk);
        #1;
        check_eq("level", 32'(host.level), 32'(mq.size()));
        check_eq("empty", 32'(host.empty), 32'(mq.size() == 0));
        check_eq("full", 32'(host.full), 32'(mq.size() == DEPTH));
        check_eq("overrun", 32'(host.overrun), 32'(m_ov));
        check_eq("perr_cnt", 32'(host.perr_cnt), 32'(m_perr));
        check_eq("irq", 32'(host.irq), 32'(m_irq));
        if (mq.size() > 0) begin
            check_eq("rd_data", 32'(host.rd_data), 32'(mq[0][7:0]));
            check_eq("rd_perr", 32'(host.rd_perr), 32'(mq[0][8]));
        end
    endtask

    task automatic send_frame(input logic [8:0] fr, input logic [1:0] cfg, input int hold,
                              input int force_rd, input bit clr);
        rx_frame = fr; cfg_parity = cfg; rx_complete = 1'b1; host.clear = 1'b0; set_rd();
        tick();
        rx_frame = 9'($urandom); cfg_parity = 2'($urandom);
        rx_complete = (hold > 1); set_rd();
        if (force_rd >= 0) host.rd_en = force_rd[0];
        host.clear = clr;
        tick();
        host.clear = 1'b0;
        for (int i = 2; i < hold; i++) begin set_rd(); tick(); end
        rx_complete = 1'b0;
        set_rd(); tick();
        set_rd(); tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; rx_complete = 1'b0; host.rd_en = 1'b0; host.clear = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] d;
        reset_n = 1'b0; rx_complete = 1'b0; rx_frame = 9'd0; cfg_parity = 2'b00;
        host.rd_en = 1'b0; host.clear = 1'b0; pop_mode = 0; m_prev_rc = 1'b0;
        do_reset();
        check_eq("rst_rd_data", 32'(host.rd_data), 32'h0);
        check_eq("rst_rd_perr", 32'(host.rd_perr), 32'h0);

        // Odd parity frame with even ones count is an error.
        send_frame(9'b0_0110_1001, 2'b01, 1, -1, 1'b0);
        check_eq("odd_data", 32'(host.rd_data), 32'h69);
        check_eq("odd_perr", 32'(host.rd_perr), 32'h1);
        check_eq("odd_cnt", 32'(host.perr_cnt), 32'h1);

        // No parity, rx_complete held for five cycles: one entry only.
        send_frame(9'b1_0101_0101, 2'b00, 5, -1, 1'b0);
        check_eq("hold_level", 32'(host.level), 32'h2);
        host.rd_en = 1'b1; tick(); host.rd_en = 1'b0;
        check_eq("nopar_data", 32'(host.rd_data), 32'hAA);
        check_eq("nopar_perr", 32'(host.rd_perr), 32'h0);

        // Fill, overflow, clear.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(9'($urandom), 2'b00, 1, -1, 1'b0);
        check_eq("fill_full", 32'(host.full), 32'h1);
        check_eq("fill_irq", 32'(host.irq), 32'h1);
        send_frame(9'($urandom), 2'b00, 1, -1, 1'b0);
        check_eq("ovr_set", 32'(host.overrun), 32'h1);
        check_eq("ovr_level", 32'(host.level), 32'h8);
        host.clear = 1'b1; tick(); host.clear = 1'b0;
        check_eq("ovr_clear", 32'(host.overrun), 32'h0);

        // Full FIFO with a pop coincident with commit: no overrun, byte lands at tail.
        send_frame(9'b1_1100_0011, 2'b00, 1, 1, 1'b0);
        check_eq("swap_ovr", 32'(host.overrun), 32'h0);
        check_eq("swap_level", 32'(host.level), 32'h8);
        for (int i = 0; i < DEPTH - 1; i++) begin host.rd_en = 1'b1; tick(); end
        host.rd_en = 1'b0; tick();
        check_eq("swap_tail", 32'(host.rd_data), 32'hE1);

        // Saturating error counter under continuous popping.
        do_reset();
        pop_mode = 1;
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            send_frame({~(^d), d}, 2'b10, 1, -1, 1'b0);
        end
        check_eq("sat_cnt", 32'(host.perr_cnt), 32'd255);
        d = 8'($urandom);
        send_frame({~(^d), d}, 2'b10, 1, -1, 1'b1);
        check_eq("clr_inc_cnt", 32'(host.perr_cnt), 32'd1);
        pop_mode = 0;

        // Reset between capture and commit with rx_complete still high.
        rx_frame = 9'h155; cfg_parity = 2'b00; rx_complete = 1'b1;
        tick();
        reset_n = 1'b0; tick();
        reset_n = 1'b1; tick(); tick(); tick();
        check_eq("mid_level", 32'(host.level), 32'h0);
        check_eq("mid_rd_data", 32'(host.rd_data), 32'h0);
        check_eq("mid_perr_cnt", 32'(host.perr_cnt), 32'h0);
        rx_complete = 1'b0; tick();
        send_frame(9'h0F3, 2'b01, 1, -1, 1'b0);
        check_eq("mid_after", 32'(host.level), 32'h1);

        // Randomized traffic: modes, hold lengths, pops and clears.
        do_reset();
        pop_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send_frame(9'($urandom), 2'($urandom), int'($urandom_range(1, 4)), -1,
                       ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
